// File: rtl/sha256_pkg.sv
// ---------------------------------------------------------------------------
// sha256_pkg
// Shared definitions for the SHA-256 round controller:
//   - stateT   : controller states IDLE, LOAD, ROUND, FINAL, DONE
//   - IV       : initial hash values H0..H7
//   - K        : 64 round constants
//   - rotr, bigSigma0, bigSigma1, smallSigma0, smallSigma1, ch, maj :
//     32-bit combinational helpers used by the round and schedule logic
// No ports (package).
// ---------------------------------------------------------------------------
package sha256_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ROUND,
      FINAL,
      DONE
   } stateT;

   localparam logic [31:0] IV [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // Rotate right by a fixed amount (n is always a constant 1..31 here)
   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bigSigma0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bigSigma1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] smallSigma0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] smallSigma1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                      input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

endpackage

// File: rtl/sha256_round_ctrl_if.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl_if
// Bundles the message-input handshake and the digest-output handshake of the
// SHA-256 round controller.
//   msg_valid/msg_ready/msg_word/block_first : padder -> controller words
//   busy                                     : controller occupied
//   digest/digest_valid/digest_ready         : controller -> consumer digest
// Modports: master (padder + consumer side), slave (controller side).
// ---------------------------------------------------------------------------
interface sha256_round_ctrl_if;
   logic         msg_valid;
   logic         msg_ready;
   logic [31:0]  msg_word;
   logic         block_first;
   logic         busy;
   logic [255:0] digest;
   logic         digest_valid;
   logic         digest_ready;

   modport master (
      output msg_valid, msg_word, block_first, digest_ready,
      input  msg_ready, busy, digest, digest_valid
   );

   modport slave (
      input  msg_valid, msg_word, block_first, digest_ready,
      output msg_ready, busy, digest, digest_valid
   );
endinterface

// File: rtl/sha256_msg_sched.sv
// ---------------------------------------------------------------------------
// sha256_msg_sched
// 16-entry message schedule shift buffer. While loading, each accepted word
// enters at the top so that after 16 words entry 0 holds W[0]. While running
// rounds, the buffer shifts by one and appends the next expanded word, so
// entry 0 always presents W[t] for the current round.
// Ports:
//   clock, reset  : clock and synchronous active-high reset
//   loadEn_i      : accept loadWord_i into the buffer this cycle
//   loadWord_i    : incoming message word
//   shiftEn_i     : advance one round (shift + expand)
//   wordT_o       : W[t] for the current round
// ---------------------------------------------------------------------------
module sha256_msg_sched
   import sha256_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        loadEn_i,
   input  logic [31:0] loadWord_i,
   input  logic        shiftEn_i,
   output logic [31:0] wordT_o
);

   logic [31:0] buf_q [16];
   logic [31:0] buf_d [16];
   logic [31:0] expanded;

   // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], with W[t] sitting in entry 0
   always_comb begin
      expanded = smallSigma1(buf_q[14]) + buf_q[9] + smallSigma0(buf_q[1]) + buf_q[0];
   end

   // Both load and round shift move the buffer down by one; they differ only in what enters at the top
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         buf_d[i] = buf_q[i];
      end
      if (loadEn_i || shiftEn_i) begin
         for (int i = 0; i < 15; i++) begin
            buf_d[i] = buf_q[i + 1];
         end
         buf_d[15] = loadEn_i ? loadWord_i : expanded;
      end
   end

   // Buffer register; reset clears any partially loaded block
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 16; i++) begin
            buf_q[i] <= buf_d[i];
         end
      end
   end

   assign wordT_o = buf_q[0];

endmodule

// File: rtl/sha256_round_ctrl.sv
// ---------------------------------------------------------------------------
// sha256_round_ctrl
// Sequencer for one SHA-256 compression: takes a 512-bit block as 16 words,
// runs ROUNDS rounds (one per cycle), adds the chaining hash and presents the
// 256-bit digest until the consumer takes it.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   bus (slave)  : msg_valid/msg_ready/msg_word/block_first in, busy,
//                  digest/digest_valid out, digest_ready in
// Parameters:
//   ROUNDS       : rounds per block (64 for real SHA-256; smaller only for debug)
// Build option:
//   SHA256_CHAIN_EN : when defined, H0..H7 carry over between blocks and
//                     block_first=1 on word 0 reloads the IV; when undefined
//                     every block starts from the IV and block_first is unused.
// ---------------------------------------------------------------------------
module sha256_round_ctrl
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64
) (
   input logic               clock,
   input logic               reset,
   sha256_round_ctrl_if.slave bus
);

   stateT        state_q, state_d;
   logic [3:0]   wordCnt_q, wordCnt_d;
   logic [6:0]   roundCnt_q, roundCnt_d;
   logic [31:0]  wv_q [8];
   logic [31:0]  wv_d [8];
   logic [31:0]  hv_q [8];
   logic [31:0]  hv_d [8];
   logic [255:0] digest_q, digest_d;
   logic         digestValid_q, digestValid_d;

   logic         msgReady;
   logic         wordTaken;
   logic         schedShift;
   logic [31:0]  wordT;
   logic [31:0]  t1, t2;
   logic [31:0]  hvSum [8];

`ifndef SHA256_CHAIN_EN
   logic unusedBlockFirst;
   assign unusedBlockFirst = bus.block_first;
`endif

   // Ready is forced low while reset is asserted so nothing is accepted during reset
   assign msgReady   = !reset && (state_q == IDLE || state_q == LOAD);
   assign wordTaken  = bus.msg_valid && msgReady;
   assign schedShift = (state_q == ROUND);

   sha256_msg_sched u_sched (
      .clock      (clock),
      .reset      (reset),
      .loadEn_i   (wordTaken),
      .loadWord_i (bus.msg_word),
      .shiftEn_i  (schedShift),
      .wordT_o    (wordT)
   );

   // Round function terms and the chaining sums, all mod 2^32 by truncation
   always_comb begin
      t1 = wv_q[7] + bigSigma1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6])
           + K[roundCnt_q[5:0]] + wordT;
      t2 = bigSigma0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
      for (int i = 0; i < 8; i++) begin
         hvSum[i] = hv_q[i] + wv_q[i];
      end
   end

   // Next-state logic: FSM transitions, counters, working variables and hash registers
   always_comb begin
      state_d       = state_q;
      wordCnt_d     = wordCnt_q;
      roundCnt_d    = roundCnt_q;
      digest_d      = digest_q;
      digestValid_d = digestValid_q;
      for (int i = 0; i < 8; i++) begin
         wv_d[i] = wv_q[i];
         hv_d[i] = hv_q[i];
      end

      case (state_q)
         IDLE: begin
            if (wordTaken) begin
               wordCnt_d = 4'd1;
               state_d   = LOAD;
`ifdef SHA256_CHAIN_EN
               for (int i = 0; i < 8; i++) begin
                  hv_d[i] = bus.block_first ? IV[i] : hv_q[i];
                  wv_d[i] = bus.block_first ? IV[i] : hv_q[i];
               end
`else
               for (int i = 0; i < 8; i++) begin
                  hv_d[i] = IV[i];
                  wv_d[i] = IV[i];
               end
`endif
            end
         end
         LOAD: begin
            if (wordTaken) begin
               if (wordCnt_q == 4'd15) begin
                  wordCnt_d  = 4'd0;
                  roundCnt_d = 7'd0;
                  state_d    = ROUND;
               end else begin
                  wordCnt_d = wordCnt_q + 4'd1;
               end
            end
         end
         ROUND: begin
            wv_d[0] = t1 + t2;
            wv_d[1] = wv_q[0];
            wv_d[2] = wv_q[1];
            wv_d[3] = wv_q[2];
            wv_d[4] = wv_q[3] + t1;
            wv_d[5] = wv_q[4];
            wv_d[6] = wv_q[5];
            wv_d[7] = wv_q[6];
            if (roundCnt_q == 7'(ROUNDS - 1)) begin
               roundCnt_d = 7'd0;
               state_d    = FINAL;
            end else begin
               roundCnt_d = roundCnt_q + 7'd1;
            end
         end
         FINAL: begin
            for (int i = 0; i < 8; i++) begin
               hv_d[i] = hvSum[i];
            end
            digest_d = {hvSum[0], hvSum[1], hvSum[2], hvSum[3],
                        hvSum[4], hvSum[5], hvSum[6], hvSum[7]};
            state_d  = DONE;
         end
         DONE: begin
            // Valid rises on the first DONE edge; ready is only honoured once valid is up
            if (!digestValid_q) begin
               digestValid_d = 1'b1;
            end else if (bus.digest_ready) begin
               digestValid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset back to IDLE and IV
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         wordCnt_q     <= '0;
         roundCnt_q    <= '0;
         digest_q      <= '0;
         digestValid_q <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            wv_q[i] <= IV[i];
            hv_q[i] <= IV[i];
         end
      end else begin
         state_q       <= state_d;
         wordCnt_q     <= wordCnt_d;
         roundCnt_q    <= roundCnt_d;
         digest_q      <= digest_d;
         digestValid_q <= digestValid_d;
         for (int i = 0; i < 8; i++) begin
            wv_q[i] <= wv_d[i];
            hv_q[i] <= hv_d[i];
         end
      end
   end

   assign bus.msg_ready    = msgReady;
   assign bus.busy         = (state_q != IDLE);
   assign bus.digest       = digest_q;
   assign bus.digest_valid = digestValid_q;

endmodule
